// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the timed data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int CNT_W          = 4;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_DEPTH_LOG2 = 10;

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request/response bundle between pipeline (master) and responder (slave).
interface dmem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              flush;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, flush,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, flush,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous word RAM; the read register only updates on re.
module dmem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Contents are never reset; only the read-out register is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Timed data-memory slave: one access at a time, programmable latency, stall and response pulse.
// state   | meaning
// IDLE    | ready for a request
// BUSY    | counting down the access latency; access at counter==0
// RESP    | one-cycle response (masked by flush)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              err_q;
    logic              rd_zero;
    logic [DATA_W-1:0] ram_rdata;

    logic in_range;
    logic access;
    logic ram_we;
    logic ram_re;

    assign in_range = (cap_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign access   = (state == ST_BUSY) && (cnt == '0) && !bus.flush;
    assign ram_we   = access && cap_wr && in_range;
    assign ram_re   = access && !cap_wr && in_range;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cap_addr[DEPTH_LOG2-1:0]),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            err_q     <= 1'b0;
            rd_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        cap_wr    <= bus.req_wr;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_RESP;
                        err_q <= !in_range;
                        // Out-of-range loads read as zero without touching the RAM register.
                        if (!cap_wr) rd_zero <= !in_range;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.stall      = ((state == ST_IDLE) && bus.req_valid && !bus.flush) ||
                            (state == ST_BUSY) ||
                            ((state == ST_RESP) && bus.flush);
    assign bus.resp_valid = (state == ST_RESP) && !bus.flush;
    assign bus.resp_rdata = rd_zero ? '0 : ram_rdata;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(16), .DATA_W(16)) a_if ();
    dmem_if #(.ADDR_W(16), .DATA_W(16)) b_if ();

    data_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (a_if.slave)
    );
    data_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (b_if.slave)
    );

    // Drives one request on a_if and follows it to the response cycle (negedge+1 of RESP).
    task automatic access_a(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                            input bit no_wait, output int lat, output logic [15:0] rd,
                            output logic er, output int bad, output int rdy);
        if (!no_wait) @(negedge clk);
        a_if.req_valid = 1'b1;
        a_if.req_wr    = wr;
        a_if.req_addr  = addr;
        a_if.req_wdata = wd;
        lat = 0; bad = 0; rdy = 0; rd = '0; er = 1'b0;
        #1;
        if (!no_wait && (a_if.stall !== 1'b1 || a_if.req_ready !== 1'b1)) bad++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (a_if.resp_valid === 1'b1) begin
                lat = k;
                rd  = a_if.resp_rdata;
                er  = a_if.resp_err;
                if (a_if.stall !== 1'b0 || a_if.req_ready !== 1'b0) bad++;
                break;
            end
            if (a_if.stall !== 1'b1) bad++;
            if (a_if.req_ready === 1'b1) rdy++;
        end
        a_if.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (a_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", a_if.resp_valid); end
        n_cmp++; if (a_if.resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", a_if.resp_rdata); end
        n_cmp++; if (a_if.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", a_if.resp_err); end
        n_cmp++; if (a_if.req_ready !== 1'b1 || a_if.stall !== 1'b0) begin n_fail++; $display("FAIL reset_ready_stall got %b%b want 10", a_if.req_ready, a_if.stall); end
    endtask

    task automatic test_store_load();
        int lat, bad, rdy; logic [15:0] rd; logic er;
        access_a(1'b1, 16'h0010, 16'h1234, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL store_latency got %0d want 5", lat); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got %b want 0", er); end
        n_cmp++; if (bad !== 0 || rdy !== 0) begin n_fail++; $display("FAIL store_stall_ready got bad=%0d rdy=%0d want 0/0", bad, rdy); end
        access_a(1'b0, 16'h0010, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL load_latency got %0d want 5", lat); end
        n_cmp++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL load_data got %h want 1234", rd); end
        n_cmp++; if (bad !== 0 || rdy !== 0) begin n_fail++; $display("FAIL load_stall_ready got bad=%0d rdy=%0d want 0/0", bad, rdy); end
    endtask

    task automatic test_back_to_back();
        int lat, bad, rdy; logic [15:0] rd; logic er;
        access_a(1'b1, 16'h03FF, 16'hBEEF, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (lat !== 5 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_store got lat=%0d err=%b want 5/0", lat, er); end
        // Second request presented during RESP: accepted only in the following IDLE cycle.
        access_a(1'b0, 16'h03FF, 16'h0000, 1'b1, lat, rd, er, bad, rdy);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_latency got %0d want 6", lat); end
        n_cmp++; if (rdy !== 1 || bad !== 0) begin n_fail++; $display("FAIL b2b_ready got rdy=%0d bad=%0d want 1/0", rdy, bad); end
        n_cmp++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data got %h want beef", rd); end
    endtask

    task automatic test_out_of_range();
        int lat, bad, rdy; logic [15:0] rd; logic er;
        access_a(1'b1, 16'h0000, 16'h0F0F, 1'b0, lat, rd, er, bad, rdy);
        access_a(1'b1, 16'h0400, 16'hAAAA, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (lat !== 5 || er !== 1'b1) begin n_fail++; $display("FAIL oor_store got lat=%0d err=%b want 5/1", lat, er); end
        access_a(1'b0, 16'h0400, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (er !== 1'b1 || rd !== 16'h0000) begin n_fail++; $display("FAIL oor_load got err=%b data=%h want 1/0000", er, rd); end
        access_a(1'b0, 16'h0000, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (er !== 1'b0 || rd !== 16'h0F0F) begin n_fail++; $display("FAIL oor_alias got err=%b data=%h want 0/0f0f", er, rd); end
    endtask

    task automatic test_flush_busy();
        int lat, bad, rdy, seen; logic [15:0] rd; logic er;
        access_a(1'b1, 16'h0020, 16'h1111, 1'b0, lat, rd, er, bad, rdy);
        // Request with flush in IDLE is ignored.
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wr = 1'b1; a_if.req_addr = 16'h0020; a_if.req_wdata = 16'h5555;
        a_if.flush = 1'b1;
        #1;
        n_cmp++; if (a_if.stall !== 1'b0) begin n_fail++; $display("FAIL idle_flush_stall got %b want 0", a_if.stall); end
        @(negedge clk); #1;
        n_cmp++; if (a_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_flush_accept got ready=%b want 1", a_if.req_ready); end
        a_if.flush = 1'b0;
        @(negedge clk);                        // acceptance cycle t+0 ends here
        @(negedge clk);                        // first BUSY cycle
        a_if.flush = 1'b1; a_if.req_valid = 1'b0;
        @(negedge clk); #1;                    // second BUSY cycle was flushed
        n_cmp++; if (a_if.req_ready !== 1'b1 || a_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL busy_flush_idle got ready=%b rv=%b want 1/0", a_if.req_ready, a_if.resp_valid); end
        a_if.flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (a_if.resp_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL busy_flush_noresp got %0d pulses want 0", seen); end
        access_a(1'b0, 16'h0020, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL busy_flush_nowrite got %h want 1111", rd); end
    endtask

    task automatic test_flush_resp();
        int lat, bad, rdy; logic [15:0] rd; logic er;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            a_if.req_valid = 1'b1; a_if.req_wr = (pass == 1); a_if.req_addr = 16'h0030; a_if.req_wdata = 16'h7777;
            for (int k = 0; k < 5; k++) @(negedge clk);
            a_if.flush = 1'b1;                 // this is the RESP cycle
            #1;
            n_cmp++; if (a_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_flush_valid pass%0d got %b want 0", pass, a_if.resp_valid); end
            n_cmp++; if (a_if.stall !== 1'b1) begin n_fail++; $display("FAIL resp_flush_stall pass%0d got %b want 1", pass, a_if.stall); end
            @(negedge clk);
            a_if.flush = 1'b0; a_if.req_valid = 1'b0;
        end
        access_a(1'b0, 16'h0030, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (rd !== 16'h7777) begin n_fail++; $display("FAIL resp_flush_commit got %h want 7777", rd); end
    endtask

    task automatic test_async_reset();
        int lat, bad, rdy; logic [15:0] rd; logic er;
        access_a(1'b1, 16'h0040, 16'h2222, 1'b0, lat, rd, er, bad, rdy);
        access_a(1'b0, 16'h0040, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wr = 1'b1; a_if.req_addr = 16'h0040; a_if.req_wdata = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        #2; rst_n = 1'b0; a_if.req_valid = 1'b0;
        #1;
        n_cmp++; if (a_if.resp_rdata !== 16'h0000 || a_if.resp_err !== 1'b0) begin n_fail++; $display("FAIL arst_outputs got data=%h err=%b want 0000/0", a_if.resp_rdata, a_if.resp_err); end
        n_cmp++; if (a_if.req_ready !== 1'b1 || a_if.stall !== 1'b0) begin n_fail++; $display("FAIL arst_idle got ready=%b stall=%b want 1/0", a_if.req_ready, a_if.stall); end
        @(negedge clk); rst_n = 1'b1;
        access_a(1'b0, 16'h0040, 16'h0000, 1'b0, lat, rd, er, bad, rdy);
        n_cmp++; if (rd !== 16'h2222) begin n_fail++; $display("FAIL arst_nowrite got %h want 2222", rd); end
    endtask

    task automatic test_latency1();
        int lat;
        logic [15:0] rd;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            b_if.req_valid = 1'b1; b_if.req_wr = (pass == 0); b_if.req_addr = 16'h0005; b_if.req_wdata = 16'hCAFE;
            lat = 0; rd = '0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk); #1;
                if (b_if.resp_valid === 1'b1) begin lat = k; rd = b_if.resp_rdata; break; end
            end
            b_if.req_valid = 1'b0;
            n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lat1_latency pass%0d got %0d want 2", pass, lat); end
        end
        n_cmp++; if (rd !== 16'hCAFE) begin n_fail++; $display("FAIL lat1_data got %h want cafe", rd); end
    endtask

    initial begin
        a_if.req_valid = 1'b0; a_if.req_wr = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.flush = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_wr = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.flush = 1'b0;
        test_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_flush_busy();
        test_flush_resp();
        test_async_reset();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder that serves the memory-stage request interface: accepts one load/store, waits a programmable access latency, then returns read data with a one-cycle response pulse.
- Drives a stall back to the pipeline while an access is outstanding.
- Replaces the zero-latency ideal memory with a realistic timed slave, keeping the same 16-bit word-addressed data model.

Parameters:
- ADDR_W, 16: request address width; word address.
- DATA_W, 16: data word width.
- DEPTH_LOG2, 10: log2 of the implemented word count (1024 words).
- LATENCY, 4: BUSY cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory-stage request present.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- flush  in  1  pipeline flush; aborts or masks the current access.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready & ~flush.
- stall  out  1  freeze upstream pipeline.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  load data; valid with resp_valid.
- resp_err  out  1  out-of-range address; valid with resp_valid.

Behaviour:
- Reset (async assert): state=IDLE, counter=0, captured request regs=0, resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not reset.
- Reset deasserts synchronously to clk. A reset mid-access drops the access; no array write occurs.
- States:
  - IDLE:
    - On acceptance, capture wr/addr/wdata, load counter with LATENCY-1, go to BUSY.
    - A request presented with flush high is ignored.
  - BUSY:
    - counter!=0: decrement.
    - counter==0: perform the access at this edge and go to RESP.
      - Store in range: write array[addr[DEPTH_LOG2-1:0]].
      - Load: register array data into resp_rdata.
  - RESP:
    - resp_valid=1 for exactly one cycle, then go to IDLE.
    - A new request is not accepted in RESP.
- Latency: acceptance in cycle t gives resp_valid high in cycle t+LATENCY+1. The next acceptance is possible at t+LATENCY+2.
- stall = (IDLE & req_valid & ~flush) | BUSY | (RESP & flush). The pipeline holds the request stable until resp_valid.
- Out of range (req_addr >= 2**DEPTH_LOG2):
  - Store is dropped; load returns resp_rdata=0.
  - resp_err=1 with resp_valid.
- resp_rdata:
  - Holds its value until the next load completes.
  - Stores leave resp_rdata unchanged.
  - resp_err clears on the next completed response.
- Flush:
  - In IDLE: the request is not accepted.
  - In BUSY: abort, no array write, no response; go to IDLE next edge.
  - In RESP: resp_valid forced 0. A completed store remains committed.
- Flush and counter==0 in the same BUSY cycle: flush wins; no write.
- Only one access is ever outstanding, so read-after-write ordering is inherent.

Decomposition:
- Package dmem_pkg:
  - State enum {IDLE, BUSY, RESP} (2-bit encoding).
  - Counter width localparam (4 bits).
  - Default LATENCY/DEPTH_LOG2 constants.
- Sub-module dmem_array:
  - Single-port synchronous RAM, DATA_W x 2**DEPTH_LOG2.
  - Ports: clk, we, addr, wdata, rdata (registered read).
  - The FSM asserts the read enable in the last BUSY cycle.

Test Plan:
- Reset then store/load, LATENCY=4: store 0x1234 to addr 0x0010, accepted cycle t → resp_valid at t+5, resp_err=0. Load 0x0010 → resp_rdata=0x1234 at its +5 cycle. stall is high from acceptance through BUSY, low in RESP.
- Back-to-back: store addr 0x03FF=0xBEEF then immediate load 0x03FF → second acceptance exactly at t+6, returns 0xBEEF. req_ready is low in BUSY/RESP.
- Out of range: store 0xAAAA to 0x0400, then load 0x0400 → resp_err=1, resp_rdata=0. Load 0x0000 afterward is unaffected.
- Flush in BUSY: store 0x5555 to 0x0020, flush on 2nd BUSY cycle → no resp_valid, back in IDLE next cycle. Later load 0x0020 returns the prior value, not 0x5555.
- Flush in RESP: load with flush asserted on the response cycle → resp_valid stays 0, stall high that cycle. A store flushed in RESP is still visible on a later load.
- Async reset mid-BUSY: drop rst_n off-edge during a store → outputs 0 immediately, state IDLE, the write is not performed. LATENCY=1 regression: resp_valid at t+2.
